// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-way, 8-set cache tag-store controller.
// Address split: tag = addr[11:7], set = addr[6:4], offset = addr[3:0].
package cache_pkg;
  localparam int ADDR_W   = 12;
  localparam int TAG_W    = 5;
  localparam int SET_W    = 3;
  localparam int OFFSET_W = 4;
  localparam int NUM_WAYS = 4;
  localparam int NUM_SETS = 8;
  localparam int WAY_W    = 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef logic [1:0]       age_t;
  typedef logic [WAY_W-1:0] way_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_WAIT,
    ST_FLUSH
  } ctrl_state_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [SET_W-1:0] set_of(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: SET_W];
  endfunction
endpackage

// File: rtl/cache_if.sv
// CPU request/response, line-fill and flush signals of the cache controller.
// The controller uses the slave modport; the CPU / fill-engine side uses master.
interface cache_if;
  import cache_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic              resp_valid;
  logic              resp_hit;
  way_t              resp_way;
  logic [SET_W-1:0]  resp_set;
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  way_t              fill_way;
  logic              fill_done;
  logic              flush;
  logic              flush_done;

  modport master (
    output req_valid, req_addr, req_we, fill_done, flush,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_set,
           fill_req, fill_addr, fill_way, flush_done
  );

  modport slave (
    input  req_valid, req_addr, req_we, fill_done, flush,
    output req_ready, resp_valid, resp_hit, resp_way, resp_set,
           fill_req, fill_addr, fill_way, flush_done
  );
endinterface

// File: rtl/cache_lru_age.sv
// Age-based LRU for one set: next-age vector after touching a way, and victim
// choice (lowest-index invalid way, otherwise the way whose age is 3).
module cache_lru_age
  import cache_pkg::*;
(
  input  age_t [NUM_WAYS-1:0] ages,
  input  logic [NUM_WAYS-1:0] valid,
  input  way_t                touch_way,
  output age_t [NUM_WAYS-1:0] next_ages,
  output way_t                victim
);
  logic found;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default up front, so no path leaves a value held and no latch is inferred.
  always_comb begin
    next_ages = ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_t'(w) == touch_way)
        next_ages[w] = '0;
      else if (ages[w] < ages[touch_way])
        next_ages[w] = ages[w] + 2'd1;
    end

    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = way_t'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (ages[w] == 2'd3) victim = way_t'(w);
      end
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// Tag-store sequencer: lookup, read-miss line fill with LRU victim, write-through
// no-allocate writes, and an 8-cycle set-by-set flush. Holds tag/valid/age state only.
module cache_ctrl
  import cache_pkg::*;
(
  input logic    clk,
  input logic    rst,
  cache_if.slave bus
);
  ctrl_state_t         state;
  tag_entry_t          tag_mem [NUM_SETS][NUM_WAYS];
  age_t [NUM_WAYS-1:0] age_mem [NUM_SETS];

  logic [TAG_W-1:0]    cur_tag;
  logic [SET_W-1:0]    cur_set;
  logic                cur_we;
  logic [SET_W-1:0]    flush_cnt;

  logic [NUM_WAYS-1:0] valid_vec;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  way_t                hit_way;
  way_t                victim;
  way_t                touch_way;
  age_t [NUM_WAYS-1:0] next_ages;

  always_comb begin
    valid_vec = '0;
    hit_vec   = '0;
    hit       = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      valid_vec[w] = tag_mem[cur_set][w].valid;
      hit_vec[w]   = tag_mem[cur_set][w].valid && (tag_mem[cur_set][w].tag == cur_tag);
    end
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
    end
  end

  // A hit touches the matching way; a completed fill touches the registered victim.
  assign touch_way = (state == ST_MISS_WAIT) ? bus.fill_way : hit_way;

  cache_lru_age u_lru (
    .ages      (age_mem[cur_set]),
    .valid     (valid_vec),
    .touch_way (touch_way),
    .next_ages (next_ages),
    .victim    (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cur_tag        <= '0;
      cur_set        <= '0;
      cur_we         <= 1'b0;
      flush_cnt      <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_way   <= '0;
      bus.resp_set   <= '0;
      bus.fill_req   <= 1'b0;
      bus.fill_addr  <= '0;
      bus.fill_way   <= '0;
      bus.flush_done <= 1'b0;
      // NOTE: the tag store is a small flop array, not a RAM macro, so resetting
      // every entry is legal and required to start all-invalid with ages = way index.
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          tag_mem[s][w] <= '0;
          age_mem[s][w] <= age_t'(w);
        end
      end
    end else begin
      bus.resp_valid <= 1'b0;
      bus.flush_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.flush) begin
            bus.req_ready <= 1'b0;
            flush_cnt     <= '0;
            state         <= ST_FLUSH;
          end else if (bus.req_valid && bus.req_ready) begin
            cur_tag       <= tag_of(bus.req_addr);
            cur_set       <= set_of(bus.req_addr);
            cur_we        <= bus.req_we;
            bus.req_ready <= 1'b0;
            state         <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit || cur_we) begin
            if (hit) age_mem[cur_set] <= next_ages;
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= hit;
            bus.resp_way   <= hit ? hit_way : way_t'(0);
            bus.resp_set   <= cur_set;
            bus.req_ready  <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            bus.fill_req  <= 1'b1;
            bus.fill_addr <= {cur_tag, cur_set, {OFFSET_W{1'b0}}};
            bus.fill_way  <= victim;
            state         <= ST_MISS_WAIT;
          end
        end
        ST_MISS_WAIT: begin
          if (bus.fill_done) begin
            tag_mem[cur_set][bus.fill_way] <= '{valid: 1'b1, tag: cur_tag};
            age_mem[cur_set] <= next_ages;
            bus.fill_req     <= 1'b0;
            bus.resp_valid   <= 1'b1;
            bus.resp_hit     <= 1'b0;
            bus.resp_way     <= bus.fill_way;
            bus.resp_set     <= cur_set;
            bus.req_ready    <= 1'b1;
            state            <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++) tag_mem[flush_cnt][w].valid <= 1'b0;
          flush_cnt <= flush_cnt + 3'd1;
          if (flush_cnt == SET_W'(NUM_SETS-1)) begin
            bus.flush_done <= 1'b1;
            bus.req_ready  <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus a randomized run
// against a behavioural tag/valid/LRU model of the whole cache.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  cache_if bus();

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per-set valid/tag, and per-way age where 0 = most recent.
  bit m_valid [8][4];
  int m_tag   [8][4];
  int m_age   [8][4];

  int last_hit;
  int last_way;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = 0;
        m_age[s][w]   = w;
      end
    end
  endfunction

  function automatic void model_touch(input int s, input int way);
    int a;
    a = m_age[s][way];
    for (int w = 0; w < 4; w++) if (m_age[s][w] < a) m_age[s][w]++;
    m_age[s][way] = 0;
  endfunction

  function automatic int model_victim(input int s);
    int oldest;
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    oldest = 0;
    for (int w = 1; w < 4; w++) if (m_age[s][w] > m_age[s][oldest]) oldest = w;
    return oldest;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.fill_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  // One request end to end: handshake, latency, fill protocol, response and ages.
  task automatic access(input logic [11:0] addr, input logic we, input int fill_lat);
    int  s, t, way, guard;
    bit  hit;
    s   = int'(addr[6:4]);
    t   = int'(addr[11:7]);
    hit = 1'b0;
    way = 0;
    for (int w = 0; w < 4; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == t) begin
        hit = 1'b1;
        way = w;
      end
    end
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("req_ready_wait", int'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    check("lookup_no_resp", int'(bus.resp_valid), 0);
    check("lookup_not_ready", int'(bus.req_ready), 0);
    tick();
    if (hit || we) begin
      check("resp_valid", int'(bus.resp_valid), 1);
      check("resp_hit", int'(bus.resp_hit), int'(hit));
      check("resp_way", int'(bus.resp_way), hit ? way : 0);
      check("resp_set", int'(bus.resp_set), s);
      check("no_fill", int'(bus.fill_req), 0);
      if (hit) model_touch(s, way);
    end else begin
      way = model_victim(s);
      check("fill_req", int'(bus.fill_req), 1);
      check("fill_addr", int'(bus.fill_addr), (t << 7) | (s << 4));
      check("fill_way", int'(bus.fill_way), way);
      check("miss_no_resp", int'(bus.resp_valid), 0);
      for (int i = 0; i < fill_lat; i++) begin
        tick();
        check("fill_hold", int'(bus.fill_req), 1);
        check("fill_way_hold", int'(bus.fill_way), way);
      end
      bus.fill_done = 1'b1;
      tick();
      bus.fill_done = 1'b0;
      check("fill_resp_valid", int'(bus.resp_valid), 1);
      check("fill_resp_hit", int'(bus.resp_hit), 0);
      check("fill_resp_way", int'(bus.resp_way), way);
      check("fill_resp_set", int'(bus.resp_set), s);
      check("fill_req_drop", int'(bus.fill_req), 0);
      m_valid[s][way] = 1'b1;
      m_tag[s][way]   = t;
      model_touch(s, way);
    end
    for (int w = 0; w < 4; w++) check("age", int'(dut.age_mem[s][w]), m_age[s][w]);
    last_hit = int'(hit);
    last_way = way;
  endtask

  // Flush raised together with a request; the request is served once flush ends.
  task automatic flush_then(input logic [11:0] addr);
    int low, done, guard;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = 1'b0;
    tick();
    bus.flush = 1'b0;
    low  = 0;
    done = 0;
    while (!bus.req_ready && low < 20) begin
      low++;
      tick();
      if (bus.flush_done) done++;
    end
    check("flush_ready_low", low, 8);
    check("flush_done_cnt", done, 1);
    for (int s = 0; s < 8; s++) for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    access(addr, 1'b0, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] a;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.flush     = 1'b0;
    bus.fill_done = 1'b0;

    do_reset();
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_resp_valid", int'(bus.resp_valid), 0);
    check("rst_fill_req", int'(bus.fill_req), 0);
    check("rst_flush_done", int'(bus.flush_done), 0);

    // 1: cold read miss then hit on the same line
    access(12'h3A0, 1'b0, 2);
    check("t1_miss", last_hit, 0);
    check("t1_way", last_way, 0);
    access(12'h3AF, 1'b0, 0);
    check("t1_hit", last_hit, 1);
    check("t1_hit_way", last_way, 0);

    // 2: LRU victim after four fills, and after re-touching way 0
    do_reset();
    access(12'h020, 1'b0, 0);
    access(12'h0A0, 1'b0, 1);
    access(12'h120, 1'b0, 0);
    access(12'h1A0, 1'b0, 3);
    access(12'h220, 1'b0, 1);
    check("t2_lru_way0", last_way, 0);
    do_reset();
    access(12'h020, 1'b0, 0);
    access(12'h0A0, 1'b0, 0);
    access(12'h120, 1'b0, 0);
    access(12'h1A0, 1'b0, 0);
    access(12'h020, 1'b0, 0);
    check("t2_rehit", last_hit, 1);
    access(12'h220, 1'b0, 0);
    check("t2_lru_way1", last_way, 1);

    // 3: write miss does not allocate
    do_reset();
    access(12'h3A0, 1'b1, 0);
    check("t3_write_miss", last_hit, 0);
    access(12'h3A0, 1'b0, 0);
    check("t3_read_still_miss", last_hit, 0);

    // 4: flush wins over a simultaneous request and invalidates everything
    do_reset();
    access(12'h020, 1'b0, 0);
    access(12'h0A0, 1'b0, 0);
    access(12'h120, 1'b0, 0);
    flush_then(12'h020);
    check("t4_miss0", last_hit, 0);
    access(12'h0A0, 1'b0, 0);
    check("t4_miss1", last_hit, 0);
    access(12'h120, 1'b0, 0);
    check("t4_miss2", last_hit, 0);

    // 5: reset while waiting for a fill
    do_reset();
    bus.req_addr  = 12'h3A0;
    bus.req_we    = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t5_fill_req", int'(bus.fill_req), 1);
    tick();
    rst = 1'b1;
    tick();
    check("t5_fill_req_rst", int'(bus.fill_req), 0);
    rst = 1'b0;
    tick();
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    check("t5_late_done_resp", int'(bus.resp_valid), 0);
    check("t5_late_done_fill", int'(bus.fill_req), 0);
    model_reset();
    access(12'h3A0, 1'b0, 1);
    check("t5_miss", last_hit, 0);
    check("t5_way0", last_way, 0);

    // 6: randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      a = {5'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 99) == 0)
        flush_then(a);
      else
        access(a, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
